// File: rtl/add_float_host.sv
`default_nettype none
// ============================================================================
// Module   : add_float_host
// Brief    : Parallel-to-serial initiator and serial-to-parallel collector for
//            the add_float bit-serial port (operands out, sum and flags back).
// Revision : 1.0  initial release
// ============================================================================
module add_float_host #(
    parameter int TIMEOUT = 60,
    parameter int TO_W    = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        res_valid,
    output logic [31:0] res_c,
    output logic        res_over,
    output logic        res_under,
    output logic        res_err,
    output logic        res_tout,
    output logic        go,
    output logic        inpab,
    input  logic        shift,
    input  logic        out_c,
    input  logic        over,
    input  logic        under,
    input  logic        done
);

    localparam logic [TO_W-1:0] c_TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [5:0]      c_RES_BITS = 6'd32;
    localparam logic [5:0]      c_RCNT_MAX = 6'd63;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_SEND_A = 3'd2,
        S_SEND_B = 3'd3,
        S_WAIT   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_bcnt;
    logic [TO_W-1:0] r_tocnt;
    logic [63:0]     r_ab_sr;
    logic [31:0]     r_res_sr;
    logic [5:0]      r_rcnt;

    logic            w_accept;
    logic            w_capture;
    logic            w_tout_hit;
    logic            w_sending_nxt;
    logic            w_busy_nxt;
    logic [31:0]     w_res_sr_nxt;
    logic [5:0]      w_rcnt_nxt;

    assign w_accept   = (r_state == S_IDLE) && op_valid && op_ready;
    // Result bits may start streaming while B is still going out.
    assign w_capture  = shift && ((r_state == S_SEND_B) || (r_state == S_WAIT));
    assign w_tout_hit = (r_tocnt == c_TO_LAST);

    always_comb begin
        w_res_sr_nxt = r_res_sr;
        w_rcnt_nxt   = r_rcnt;
        if (w_capture) begin
            w_res_sr_nxt = {r_res_sr[30:0], out_c};
            if (r_rcnt != c_RCNT_MAX) begin
                w_rcnt_nxt = r_rcnt + 6'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_START;
            S_START:  w_state_nxt = S_SEND_A;
            S_SEND_A: if (r_bcnt == 5'd31) w_state_nxt = S_SEND_B;
            S_SEND_B: if (r_bcnt == 5'd31) w_state_nxt = S_WAIT;
            S_WAIT:   if (done || w_tout_hit) w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_sending_nxt = (w_state_nxt == S_SEND_A) || (w_state_nxt == S_SEND_B);
    assign w_busy_nxt    = (w_state_nxt == S_START) || w_sending_nxt || (w_state_nxt == S_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcnt   <= '0;
            r_tocnt  <= '0;
            r_ab_sr  <= '0;
            r_res_sr <= '0;
            r_rcnt   <= '0;
        end else begin
            r_bcnt  <= ((r_state == S_SEND_A) || (r_state == S_SEND_B)) ? r_bcnt + 5'd1 : 5'd0;
            r_tocnt <= (r_state == S_WAIT) ? r_tocnt + TO_W'(1) : '0;

            if (w_accept) begin
                r_ab_sr <= {op_a, op_b};
            end else if (w_sending_nxt) begin
                r_ab_sr <= {r_ab_sr[62:0], 1'b0};
            end

            // Fresh collection window per operation: partial results come out right-aligned.
            if (r_state == S_START) begin
                r_res_sr <= '0;
                r_rcnt   <= '0;
            end else begin
                r_res_sr <= w_res_sr_nxt;
                r_rcnt   <= w_rcnt_nxt;
            end
        end
    end

    // Every port-facing output is a flop, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            go        <= 1'b1;
            inpab     <= 1'b0;
            op_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_c     <= '0;
            res_over  <= 1'b0;
            res_under <= 1'b0;
            res_err   <= 1'b0;
            res_tout  <= 1'b0;
        end else begin
            go        <= ~w_busy_nxt;
            inpab     <= w_sending_nxt ? r_ab_sr[63] : 1'b0;
            op_ready  <= (w_state_nxt == S_IDLE);
            res_valid <= (w_state_nxt == S_RESP);

            if (r_state == S_WAIT) begin
                if (done) begin
                    res_c     <= w_res_sr_nxt;
                    res_over  <= over;
                    res_under <= under;
                    res_err   <= (w_rcnt_nxt != c_RES_BITS);
                    res_tout  <= 1'b0;
                end else if (w_tout_hit) begin
                    res_c     <= w_res_sr_nxt;
                    res_over  <= 1'b0;
                    res_under <= 1'b0;
                    res_err   <= 1'b0;
                    res_tout  <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_float_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_float_host
// Brief    : Scoreboard bench for add_float_host with a behavioural add_float.
// Revision : 1.0  initial release
// ============================================================================
module tb_add_float_host;

    localparam int TO = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        res_valid;
    logic [31:0] res_c;
    logic        res_over;
    logic        res_under;
    logic        res_err;
    logic        res_tout;
    logic        go;
    logic        inpab;
    logic        shift;
    logic        out_c;
    logic        over;
    logic        under;
    logic        done;

    add_float_host #(.TIMEOUT(TO), .TO_W(7)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_c(res_c), .res_over(res_over), .res_under(res_under),
        .res_err(res_err), .res_tout(res_tout),
        .go(go), .inpab(inpab), .shift(shift), .out_c(out_c),
        .over(over), .under(under), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] c;
        logic        ov;
        logic        un;
        logic        err;
        logic        tout;
        int          w;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    typedef struct {
        logic [63:0] stream;
        int          nshift;
        logic        ov;
        logic        un;
        bit          give_done;
        int          delay;
        bit          done_same;
    } cfg_t;

    exp_t        exp_q[$];
    cfg_t        cfg_q[$];
    logic [63:0] cap_q[$];
    int          acc_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_rv_cyc = -10;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural add_float: captures the 64 operand bits, then replays a scripted result.
    initial begin : model
        cfg_t        cf;
        logic [63:0] cap;
        bit          aborted;
        shift = 1'b0; out_c = 1'b0; done = 1'b0; over = 1'b0; under = 1'b0;
        cap = '0;
        forever begin
            @(negedge clk);
            if (!reset && go === 1'b0) begin
                if (cfg_q.size() > 0) begin
                    cf = cfg_q.pop_front();
                end else begin
                    cf.stream = '0; cf.nshift = 0; cf.ov = 1'b0; cf.un = 1'b0;
                    cf.give_done = 1'b0; cf.delay = 0; cf.done_same = 1'b0;
                end
                aborted = 1'b0;
                for (int i = 0; i < 64; i++) begin
                    @(negedge clk);
                    if (go !== 1'b0 || reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    cap = {cap[62:0], inpab};
                end
                if (!aborted) begin
                    cap_q.push_back(cap);
                    @(posedge clk); #1;
                    if (cf.give_done) begin
                        repeat (cf.delay) begin @(posedge clk); #1; end
                        for (int i = cf.nshift - 1; i >= 0; i--) begin
                            shift = 1'b1;
                            out_c = cf.stream[i];
                            if (i == 0 && cf.done_same) begin
                                done = 1'b1; over = cf.ov; under = cf.un;
                            end
                            @(posedge clk); #1;
                        end
                        shift = 1'b0; out_c = 1'b0;
                        if (!cf.done_same || cf.nshift == 0) begin
                            done = 1'b1; over = cf.ov; under = cf.un;
                            @(posedge clk); #1;
                        end
                        done = 1'b0; over = 1'b0; under = 1'b0;
                    end
                    for (int k = 0; k < 500 && go !== 1'b1; k++) @(negedge clk);
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a result is presented.
    bit   busy = 1'b0;
    bit   rdy_bad = 1'b0;
    logic prev_rv = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        int   acc;
        if (reset) begin
            acc_q.delete();
            busy    = 1'b0;
            rdy_bad = 1'b0;
            prev_rv = 1'b0;
        end else begin
            if (busy && op_ready) rdy_bad = 1'b1;
            if (op_valid && op_ready) begin
                acc_q.push_back(cyc);
                busy = 1'b1;
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_res_valid: got res_valid=1 at cycle %0d required none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_c", 64'(res_c), 64'(e.c));
                    chk("res_over", 64'(res_over), 64'(e.ov));
                    chk("res_under", 64'(res_under), 64'(e.un));
                    chk("res_err", 64'(res_err), 64'(e.err));
                    chk("res_tout", 64'(res_tout), 64'(e.tout));
                    chk("go_in_resp", 64'(go), 64'(1));
                    chk("res_valid_pulse", 64'(prev_rv), 64'(0));
                    chk("op_ready_low_while_busy", 64'(rdy_bad), 64'(0));
                    if (acc_q.size() > 0) begin
                        acc = acc_q.pop_front();
                        chk("latency", 64'(cyc - acc), 64'(66 + e.w));
                    end else begin
                        chk("accept_seen", 64'(0), 64'(1));
                    end
                    if (cap_q.size() > 0) chk("serial_operands", cap_q.pop_front(), {e.a, e.b});
                    else chk("serial_operands_seen", 64'(0), 64'(1));
                end
                last_rv_cyc = cyc;
                busy        = 1'b0;
                rdy_bad     = 1'b0;
            end
            prev_rv = res_valid;
        end
    end

    function automatic cfg_t mk_cfg(input logic [63:0] s, input int n, input logic ov, input logic un,
                                    input bit gd, input int d, input bit same);
        cfg_t c;
        c.stream = s; c.nshift = n; c.ov = ov; c.un = un;
        c.give_done = gd; c.delay = d; c.done_same = same;
        return c;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                    input logic ov, input logic un, input logic err, input logic tout,
                                    input int w);
        exp_t e;
        e.a = a; e.b = b; e.c = c; e.ov = ov; e.un = un; e.err = err; e.tout = tout; e.w = w;
        return e;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        op_a = a; op_b = b; op_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (op_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("result_timeout", 64'(0), 64'(1));
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input cfg_t c, input exp_t e);
        cfg_q.push_back(c);
        exp_q.push_back(e);
        send(a, b);
        wait_done();
    endtask

    initial begin : stimulus
        bit ok;
        int acc2;
        reset = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_go", 64'(go), 64'(1));
        chk("rst_inpab", 64'(inpab), 64'(0));
        chk("rst_op_ready", 64'(op_ready), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_res_c", 64'(res_c), 64'(0));
        chk("rst_flags", 64'({res_over, res_under, res_err, res_tout}), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("op_ready_after_rst", 64'(op_ready), 64'(1));

        // 0.5 + -0.4375 = 0.0625; done with last shift after 3 idle cycles
        run_op(32'h3F000000, 32'hBEE00000, mk_cfg(64'h3D800000, 32, 1'b0, 1'b0, 1'b1, 3, 1'b1),
               mk_exp(32'h3F000000, 32'hBEE00000, 32'h3D800000, 1'b0, 1'b0, 1'b0, 1'b0, 35));
        // same sum, done on its own cycle
        run_op(32'h3F000000, 32'hBEE00000, mk_cfg(64'h3D800000, 32, 1'b0, 1'b0, 1'b1, 0, 1'b0),
               mk_exp(32'h3F000000, 32'hBEE00000, 32'h3D800000, 1'b0, 1'b0, 1'b0, 1'b0, 33));
        // overflow: max finite + max finite -> +inf
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, mk_cfg(64'h7F800000, 32, 1'b1, 1'b0, 1'b1, 1, 1'b0),
               mk_exp(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0, 1'b0, 1'b0, 34));
        // underflow flagged by the adder
        run_op(32'h00800000, 32'h80800001, mk_cfg(64'h0, 32, 1'b0, 1'b1, 1'b1, 0, 1'b1),
               mk_exp(32'h00800000, 32'h80800001, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 32));
        // adder never finishes
        run_op(32'h40000000, 32'h40400000, mk_cfg(64'h0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0),
               mk_exp(32'h40000000, 32'h40400000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, TO));
        // 31 shifts: right-aligned partial
        run_op(32'h12345678, 32'h9ABCDEF0, mk_cfg(64'h12345678, 31, 1'b0, 1'b0, 1'b1, 2, 1'b1),
               mk_exp(32'h12345678, 32'h9ABCDEF0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 33));
        // 33 shifts: last 32 kept
        run_op(32'hC0000000, 32'h3F800000, mk_cfg(64'h1_8765_4321, 33, 1'b0, 1'b0, 1'b1, 0, 1'b0),
               mk_exp(32'hC0000000, 32'h3F800000, 32'h87654321, 1'b0, 1'b0, 1'b1, 1'b0, 34));

        // Reset during SEND_A bit 10 (operand bit 21 is the lone zero)
        send(32'hFFDFFFFF, 32'h00000000);
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("inpab_send_a_bit10", 64'(inpab), 64'(0));
        @(negedge clk);
        chk("abort_go", 64'(go), 64'(1));
        chk("abort_res_valid", 64'(res_valid), 64'(0));
        chk("abort_op_ready", 64'(op_ready), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (150) @(negedge clk);
        run_op(32'h3F800000, 32'h3F800000, mk_cfg(64'h40000000, 32, 1'b0, 1'b0, 1'b1, 4, 1'b0),
               mk_exp(32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 37));

        // Back-to-back with op_valid held high
        cfg_q.push_back(mk_cfg(64'h40400000, 32, 1'b0, 1'b0, 1'b1, 0, 1'b1));
        exp_q.push_back(mk_exp(32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0, 32));
        cfg_q.push_back(mk_cfg(64'h40A00000, 32, 1'b0, 1'b0, 1'b1, 2, 1'b0));
        exp_q.push_back(mk_exp(32'h40000000, 32'h40400000, 32'h40A00000, 1'b0, 1'b0, 1'b0, 1'b0, 35));
        @(posedge clk); #1;
        op_a = 32'h3F800000; op_b = 32'h40000000; op_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (op_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("b2b_accept1", 64'(0), 64'(1));
        @(posedge clk); #1;
        op_a = 32'h40000000; op_b = 32'h40400000;
        ok = 1'b0;
        acc2 = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (op_ready) begin ok = 1'b1; acc2 = cyc; break; end
        end
        if (!ok) chk("b2b_accept2", 64'(0), 64'(1));
        chk("b2b_one_idle_gap", 64'(acc2 - last_rv_cyc), 64'(1));
        @(posedge clk); #1;
        op_valid = 1'b0;
        wait_done();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
